fwd_stall_ctrl: RTL and testbench
=================================

# fwd_stall_ctrl

Hazard controller for the 5-stage pipeline. It tracks pending register writes in E, M and W, and drives the 3-bit selects of the two 5-input forwarding muxes in front of the D-stage operands and the two in front of the E-stage operands. It also raises the stall that freezes F/D and inserts a bubble into D/E. A saturating stall counter is kept for performance debug.

## Interface
- `WIDTH_CNT`, default 16: width of the stall counter.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `d_valid` in 1: D stage holds a real instruction.
- `d_rs`, `d_rt` in 5: D-stage source register numbers.
- `d_tuse_rs`, `d_tuse_rt` in 2: cycles until the operand is consumed (0 = D, 1 = E). 3 = not used.
- `d_wreg` in 5: destination register of the D instruction. 0 = no write.
- `d_tnew` in 2: cycles after entering E until the result exists. Jal link = 0, ALU = 1, load = 2.
- `d_md` in 1: D instruction uses the mult/div unit.
- `md_busy` in 1: mult/div unit busy.
- `stall` out 1: hold PC and F/D, clear D/E.
- `d_sel_rs`, `d_sel_rt` out 3: D mux select. 000 regfile, 001 E result, 010 M result, 011 W result, 100 zero.
- `e_sel_rs`, `e_sel_rt` out 3: E mux select. 000 D/E-registered value, 010 M, 011 W, 100 zero. 001 is never driven.
- `stall_cnt` out WIDTH_CNT: stall cycles since reset, saturating.

## Operation
- State per stage X in {E, M, W}: `vX`, `regX[4:0]`, `tnewX[1:0]`. E also holds `e_rs` and `e_rt`.
- Advance on each clock edge when `stall` = 0:
  - E takes the D entry: `v = d_valid & (d_wreg != 0)`, `reg = d_wreg`, `tnew = d_tnew`.
  - `e_rs`/`e_rt` take `d_rs`/`d_rt` (forced to 0 if `d_valid` = 0).
  - M takes E and W takes M. `tnew` decrements, saturating at 0.
- On a clock edge with `stall` = 1:
  - E takes a bubble: `v` = 0, `e_rs`/`e_rt` = 0.
  - M takes E and W takes M, with the same `tnew` decrement. The pipeline behind D keeps draining.
- Match for an operand at stage X: `vX & regX == src & src != 0`. Only the youngest matching stage counts; priority is E > M > W.
- D operand select:
  - src == 0 → 100.
  - Youngest match X with `tnewX` == 0 → the code for X.
  - No match, or youngest match with `tnewX` != 0 → 000.
- D operand stall: `d_valid & tuse != 3 & youngest match X & tnewX > tuse`.
- `stall` = rs-stall | rt-stall | (`d_valid & d_md & md_busy`). It is combinational from state and D inputs.
- E operand select, from `e_rs`/`e_rt` against M and W only (priority M > W):
  - src == 0 → 100.
  - Match with `tnew` == 0 → 010 or 011.
  - Otherwise → 000.
- The stall rule guarantees that an E consumer never sees a match with `tnew` != 0.
- `stall_cnt` increments on each edge with `stall` = 1 and holds at all-ones.

## Timing
- Reset (async, immediate):
  - All `v` = 0, `tnew` = 0, `reg` = 0, `e_rs`/`e_rt` = 0, `stall_cnt` = 0.
  - Resulting outputs: `e_sel_*` = 100. `d_sel_*` = 000, or 100 if the D src is 0. `stall` = `d_valid & d_md & md_busy`.
- Reset asserted mid-stall drops all pending tags. The first edge after release is a normal advance.
- Select and stall outputs are combinational. Zero latency from D inputs; one cycle after an edge from state.
- Forwarding timing:
  - Load → ALU consumer (tuse 1): 1 stall cycle, then `e_sel` = 011.
  - Load → branch (tuse 0): 2 stall cycles, then `d_sel` = 011.
  - ALU → branch: 1 stall cycle, then `d_sel` = 010.
  - Jal → branch: no stall, `d_sel` = 001.
- A write to $0 never matches. Simultaneous rs/rt hazards produce one stall; the selects are independent.

## Test plan
- Reset with `d_valid` = 0 → `stall` = 0, `e_sel_rs`/`e_sel_rt` = 100, `stall_cnt` = 0.
- `lw $8`, then next cycle `addu` with rs = $8 (tuse 1) → `stall` = 1 for exactly one cycle. Next cycle `e_sel_rs` = 011; `stall_cnt` = 1.
- `addu $9`, then `beq` with rs = rt = $9 (tuse 0) → 1 stall cycle. Then `d_sel_rs` = `d_sel_rt` = 010.
- `jal` (wreg $31, tnew 0), then `jr $31` → no stall, `d_sel_rs` = 001. E, M and W all writing $5 with `tnew` 0 → select picks E (001).
- `addu $0` followed by a $0 consumer → no stall, select 100. Then `d_md` = 1 with `md_busy` = 1 for 5 cycles → `stall` = 1 for 5 cycles and `stall_cnt` = 5.
- `lw $8` in E, assert `reset` mid-cycle → `stall` = 0 immediately. With WIDTH_CNT = 2 and 5 stall cycles, `stall_cnt` saturates at 3.

Source files
------------

// File: rtl/fwd_stall_ctrl.sv
// fwd_stall_ctrl
//   Hazard controller for the 5-stage pipeline. Tracks the pending register
//   write of the instructions in E, M and W, steers the four operand bypass
//   muxes (two in front of D, two in front of E) and raises the stall that
//   freezes PC/F-D and injects a bubble into D/E. A saturating stall counter
//   is kept for performance debug.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   d_valid               : D stage holds a real instruction
//   d_rs, d_rt            : D-stage source registers
//   d_tuse_rs, d_tuse_rt  : cycles until each operand is consumed (3 = unused)
//   d_wreg, d_tnew        : D destination register (0 = none) and result latency
//   d_md, md_busy         : D uses mult/div, mult/div unit busy
//   stall                 : hold PC and F/D, clear D/E
//   d_sel_rs, d_sel_rt    : D bypass select (000 RF, 001 E, 010 M, 011 W, 100 zero)
//   e_sel_rs, e_sel_rt    : E bypass select (000 D/E reg, 010 M, 011 W, 100 zero)
//   stall_cnt             : stall cycles since reset, saturating
module fwd_stall_ctrl #(
  parameter int unsigned WIDTH_CNT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 d_valid,
  input  logic [4:0]           d_rs,
  input  logic [4:0]           d_rt,
  input  logic [1:0]           d_tuse_rs,
  input  logic [1:0]           d_tuse_rt,
  input  logic [4:0]           d_wreg,
  input  logic [1:0]           d_tnew,
  input  logic                 d_md,
  input  logic                 md_busy,
  output logic                 stall,
  output logic [2:0]           d_sel_rs,
  output logic [2:0]           d_sel_rt,
  output logic [2:0]           e_sel_rs,
  output logic [2:0]           e_sel_rt,
  output logic [WIDTH_CNT-1:0] stall_cnt
);

  localparam logic [2:0] SEL_RF   = 3'b000;
  localparam logic [2:0] SEL_E    = 3'b001;
  localparam logic [2:0] SEL_M    = 3'b010;
  localparam logic [2:0] SEL_W    = 3'b011;
  localparam logic [2:0] SEL_ZERO = 3'b100;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Pending-write tags per stage
  logic       v_e, v_m, v_w;
  logic [4:0] reg_e, reg_m, reg_w;
  logic [1:0] tnew_e, tnew_m, tnew_w;
  logic [4:0] e_rs, e_rt;

  logic stall_rs, stall_rt, stall_md;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // D operand: youngest match (E > M > W) decides both the select and
  // whether the producer is too late for this consumer.
  // Returns {stall, select}.
  function automatic logic [3:0] d_resolve(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic       dv,
    input logic       ve, input logic [4:0] re, input logic [1:0] te,
    input logic       vm, input logic [4:0] rm, input logic [1:0] tm,
    input logic       vw, input logic [4:0] rw, input logic [1:0] tw
  );
    logic       nz;
    logic       found;
    logic [1:0] t;
    logic [2:0] code;
    logic [2:0] sel;
    logic       stl;
    nz    = (src != 5'd0);
    found = 1'b1;
    t     = 2'd0;
    code  = SEL_RF;
    if (nz && ve && (re == src)) begin
      t    = te;
      code = SEL_E;
    end else if (nz && vm && (rm == src)) begin
      t    = tm;
      code = SEL_M;
    end else if (nz && vw && (rw == src)) begin
      t    = tw;
      code = SEL_W;
    end else begin
      found = 1'b0;
    end

    if (!nz) begin
      sel = SEL_ZERO;
    end else if (found && (t == 2'd0)) begin
      sel = code;
    end else begin
      sel = SEL_RF;
    end

    stl = dv && (tuse != TUSE_NONE) && found && (t > tuse);
    return {stl, sel};
  endfunction

  // E operand: only M and W can still be ahead of it (M > W).
  function automatic logic [2:0] e_resolve(
    input logic [4:0] src,
    input logic       vm, input logic [4:0] rm, input logic [1:0] tm,
    input logic       vw, input logic [4:0] rw, input logic [1:0] tw
  );
    logic [2:0] sel;
    sel = SEL_RF;
    if (src == 5'd0) begin
      sel = SEL_ZERO;
    end else if (vm && (rm == src)) begin
      sel = (tm == 2'd0) ? SEL_M : SEL_RF;
    end else if (vw && (rw == src)) begin
      sel = (tw == 2'd0) ? SEL_W : SEL_RF;
    end
    return sel;
  endfunction

  always_comb begin
    {stall_rs, d_sel_rs} = d_resolve(d_rs, d_tuse_rs, d_valid,
                                     v_e, reg_e, tnew_e,
                                     v_m, reg_m, tnew_m,
                                     v_w, reg_w, tnew_w);
    {stall_rt, d_sel_rt} = d_resolve(d_rt, d_tuse_rt, d_valid,
                                     v_e, reg_e, tnew_e,
                                     v_m, reg_m, tnew_m,
                                     v_w, reg_w, tnew_w);
    e_sel_rs = e_resolve(e_rs, v_m, reg_m, tnew_m, v_w, reg_w, tnew_w);
    e_sel_rt = e_resolve(e_rt, v_m, reg_m, tnew_m, v_w, reg_w, tnew_w);
    stall_md = d_valid && d_md && md_busy;
    stall    = stall_rs || stall_rt || stall_md;
  end

  // Pipeline tags. M and W always drain; E takes either the D entry or a
  // bubble depending on stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_e    <= 1'b0;
      reg_e  <= '0;
      tnew_e <= '0;
      e_rs   <= '0;
      e_rt   <= '0;
      v_m    <= 1'b0;
      reg_m  <= '0;
      tnew_m <= '0;
      v_w    <= 1'b0;
      reg_w  <= '0;
      tnew_w <= '0;
    end else begin
      v_w    <= v_m;
      reg_w  <= reg_m;
      tnew_w <= tnew_dec(tnew_m);
      v_m    <= v_e;
      reg_m  <= reg_e;
      tnew_m <= tnew_dec(tnew_e);
      if (stall) begin
        v_e    <= 1'b0;
        reg_e  <= '0;
        tnew_e <= '0;
        e_rs   <= '0;
        e_rt   <= '0;
      end else begin
        v_e    <= d_valid && (d_wreg != 5'd0);
        reg_e  <= d_wreg;
        tnew_e <= d_tnew;
        e_rs   <= d_valid ? d_rs : 5'd0;
        e_rt   <= d_valid ? d_rt : 5'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + WIDTH_CNT'(1);
    end
  end

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
module tb_fwd_stall_ctrl;

  logic       clk;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_wreg;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md, md_busy;

  logic        stall, stall2;
  logic [2:0]  d_sel_rs, d_sel_rt, e_sel_rs, e_sel_rt;
  logic [2:0]  d_sel_rs2, d_sel_rt2, e_sel_rs2, e_sel_rt2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  fwd_stall_ctrl #(.WIDTH_CNT(16)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wreg(d_wreg), .d_tnew(d_tnew),
    .d_md(d_md), .md_busy(md_busy), .stall(stall), .d_sel_rs(d_sel_rs),
    .d_sel_rt(d_sel_rt), .e_sel_rs(e_sel_rs), .e_sel_rt(e_sel_rt),
    .stall_cnt(stall_cnt)
  );

  fwd_stall_ctrl #(.WIDTH_CNT(2)) dut_small (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wreg(d_wreg), .d_tnew(d_tnew),
    .d_md(d_md), .md_busy(md_busy), .stall(stall2), .d_sel_rs(d_sel_rs2),
    .d_sel_rt(d_sel_rt2), .e_sel_rs(e_sel_rs2), .e_sel_rt(e_sel_rt2),
    .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic [2:0]  drs, drt, ers, ert;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 0;

  // Reference model: the last three issue slots, youngest first
  // (slot 0 = E, 1 = M, 2 = W). A result issued with latency n in slot k
  // still needs max(0, n - k) cycles.
  logic       m_v[3];
  logic [4:0] m_reg[3];
  int         m_tn[3];
  logic [4:0] m_rs, m_rt;
  int         m_cnt;

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 1'b0; m_reg[k] = 5'd0; m_tn[k] = 0;
    end
    m_rs = 5'd0; m_rt = 5'd0; m_cnt = 0;
  endfunction

  function automatic int remaining(int k);
    return (m_tn[k] > k) ? m_tn[k] - k : 0;
  endfunction

  function automatic int youngest(logic [4:0] src, int first);
    if (src == 5'd0) return -1;
    for (int k = first; k < 3; k++)
      if (m_v[k] && m_reg[k] == src) return k;
    return -1;
  endfunction

  function automatic logic [2:0] ref_sel(logic [4:0] src, int first);
    int k;
    if (src == 5'd0) return 3'd4;
    k = youngest(src, first);
    if (k >= 0 && remaining(k) == 0) return 3'(k + 1);
    return 3'd0;
  endfunction

  function automatic logic ref_dstall(logic [4:0] src, logic [1:0] tuse);
    int k;
    k = youngest(src, 0);
    return d_valid && tuse != 2'd3 && k >= 0 && remaining(k) > int'(tuse);
  endfunction

  function automatic exp_t compute_exp();
    exp_t e;
    e.stall = ref_dstall(d_rs, d_tuse_rs) || ref_dstall(d_rt, d_tuse_rt) ||
              (d_valid && d_md && md_busy);
    e.drs  = ref_sel(d_rs, 0);
    e.drt  = ref_sel(d_rt, 0);
    e.ers  = ref_sel(m_rs, 1);
    e.ert  = ref_sel(m_rt, 1);
    e.cnt  = (m_cnt > 65535) ? 16'hffff : 16'(m_cnt);
    e.cnt2 = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    return e;
  endfunction

  function automatic void model_advance(logic stl);
    for (int k = 2; k > 0; k--) begin
      m_v[k] = m_v[k-1]; m_reg[k] = m_reg[k-1]; m_tn[k] = m_tn[k-1];
    end
    if (stl) begin
      m_v[0] = 1'b0; m_reg[0] = 5'd0; m_tn[0] = 0; m_rs = 5'd0; m_rt = 5'd0;
      m_cnt++;
    end else begin
      m_v[0]   = d_valid && d_wreg != 5'd0;
      m_reg[0] = d_wreg;
      m_tn[0]  = int'(d_tnew);
      m_rs     = d_valid ? d_rs : 5'd0;
      m_rt     = d_valid ? d_rt : 5'd0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (!done && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("stall",      32'(stall),      32'(e.stall));
        chk("stall_w2",   32'(stall2),     32'(e.stall));
        chk("d_sel_rs",   32'(d_sel_rs),   32'(e.drs));
        chk("d_sel_rt",   32'(d_sel_rt),   32'(e.drt));
        chk("e_sel_rs",   32'(e_sel_rs),   32'(e.ers));
        chk("e_sel_rt",   32'(e_sel_rt),   32'(e.ert));
        chk("stall_cnt",  32'(stall_cnt),  32'(e.cnt));
        chk("stall_cnt2", 32'(stall_cnt2), 32'(e.cnt2));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] urs, input logic [1:0] urt,
                        input logic [4:0] wr, input logic [1:0] tn,
                        input logic md, input logic busy);
    d_valid = v; d_rs = rs; d_rt = rt; d_tuse_rs = urs; d_tuse_rt = urt;
    d_wreg = wr; d_tnew = tn; d_md = md; md_busy = busy;
  endtask

  // Called at posedge+1: push expectation, cross the edge, update model.
  task automatic step(output logic stl);
    exp_t e;
    e = compute_exp();
    sbq.push_back(e);
    stl = e.stall;
    @(posedge clk);
    if (reset) model_reset();
    else model_advance(e.stall);
    #1;
  endtask

  task automatic apply(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] urs, input logic [1:0] urt,
                       input logic [4:0] wr, input logic [1:0] tn,
                       input logic md, input logic busy);
    logic s;
    set_in(v, rs, rt, urs, urt, wr, tn, md, busy);
    step(s);
  endtask

  task automatic idle();
    apply(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset away from any edge; outputs must clear at once.
  task automatic do_reset();
    exp_t e;
    reset = 1'b1;
    #1;
    model_reset();
    e = compute_exp();
    chk("rst_stall",    32'(stall),      32'(e.stall));
    chk("rst_e_sel_rs", 32'(e_sel_rs),   32'd4);
    chk("rst_e_sel_rt", 32'(e_sel_rt),   32'd4);
    chk("rst_d_sel_rs", 32'(d_sel_rs),   32'(e.drs));
    chk("rst_cnt",      32'(stall_cnt),  32'd0);
    chk("rst_cnt2",     32'(stall_cnt2), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic s;
    exp_t e;
    reset = 1'b0;
    set_in(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0);
    model_reset();
    #1;
    do_reset();

    // lw $8 then addu rs=$8: one stall, then E bypass from W
    apply(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0);
    apply(1'b1, 5'd8, 5'd9, 2'd1, 2'd1, 5'd10, 2'd1, 1'b0, 1'b0);
    apply(1'b1, 5'd8, 5'd9, 2'd1, 2'd1, 5'd10, 2'd1, 1'b0, 1'b0);
    idle();
    idle();

    // addu $9 then beq $9,$9
    apply(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd9, 2'd1, 1'b0, 1'b0);
    apply(1'b1, 5'd9, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    apply(1'b1, 5'd9, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    idle();

    // lw $7 then beq $7: two stalls
    apply(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      apply(1'b1, 5'd7, 5'd3, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    idle();

    // jal then jr $31
    apply(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0);
    apply(1'b1, 5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0);

    // $5 in E, M and W together
    for (int i = 0; i < 3; i++)
      apply(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd0, 1'b0, 1'b0);
    apply(1'b1, 5'd5, 5'd5, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);

    // write to $0 never matches
    apply(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd1, 1'b0, 1'b0);
    apply(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);

    // mult/div busy for 5 cycles from a clean counter
    do_reset();
    for (int i = 0; i < 5; i++)
      apply(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1);
    idle();
    chk("md_cnt",  32'(stall_cnt),  32'd5);
    chk("md_cnt2", 32'(stall_cnt2), 32'd3);

    // reset while a load-use stall is showing
    apply(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0);
    set_in(1'b1, 5'd8, 5'd0, 2'd1, 2'd3, 5'd4, 2'd1, 1'b0, 1'b0);
    e = compute_exp();
    sbq.push_back(e);
    @(negedge clk);
    #1;
    do_reset();
    chk("post_rst_stall", 32'(stall), 32'd0);
    step(s);
    idle();

    // Randomized traffic; a stalled D instruction is held
    s = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (n % 500 == 499) begin
        @(negedge clk);
        #1;
        do_reset();
      end
      if (!s) begin
        d_valid   = ($urandom % 8) != 0;
        d_rs      = 5'($urandom % 8);
        d_rt      = 5'($urandom % 8);
        d_tuse_rs = 2'($urandom % 4);
        d_tuse_rt = 2'($urandom % 4);
        d_wreg    = 5'($urandom % 8);
        d_tnew    = 2'($urandom_range(0, 2));
        d_md      = ($urandom % 6) == 0;
      end
      md_busy = ($urandom % 3) == 0;
      step(s);
    end

    chk("queue_drained", 32'(sbq.size()), 32'd0);
    done = 1;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
